// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU decoder and multiply/divide sequencer.
// Divide support is compiled in only when ALU_MULDIV_DIV_EN is defined.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_FUNCT = 2'b10;
  localparam logic [1:0] AOP_AND   = 2'b11;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  typedef enum logic [1:0] {MULT, MULTU, DIV, DIVU} mdop_t;

  function automatic logic is_signed_op(input mdop_t op);
    return (op == MULT) || (op == DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_ctrl_if.sv
// Controller/datapath bundle for alu_muldiv_ctrl; master = main controller side.
interface alu_muldiv_ctrl_if import alu_pkg::*; #(parameter int WIDTH = 32);
  // Handshake: start is a one-cycle launch pulse honoured only while busy=0;
  // busy stays high until HI/LO are written, then done pulses for one cycle
  // (busy already low), and start in that same cycle is accepted.
  logic [5:0]       funct;
  logic [1:0]       aluop;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alucontrol;
  logic             illegal;
  logic [WIDTH-1:0] hilo_out;
  logic             busy;
  logic             done;
  logic             stall;
  state_t           state;

  modport master (output funct, aluop, start, a, b,
                  input  alucontrol, illegal, hilo_out, busy, done, stall, state);
  modport slave  (input  funct, aluop, start, a, b,
                  output alucontrol, illegal, hilo_out, busy, done, stall, state);
endinterface

// File: rtl/muldiv_engine.sv
// Iterative shift-add multiplier / restoring divider over operand magnitudes.
// Divider path exists only with ALU_MULDIV_DIV_EN; sign fix is applied on the result side.
module muldiv_engine import alu_pkg::*; #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  mdop_t            op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH:0]       acc;
  logic [WIDTH-1:0]     mq, opb, mag_a, mag_b;
  logic [CW-1:0]        cnt;
  logic                 neg_q, a_neg, b_neg;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod, prod_f;
`ifdef ALU_MULDIV_DIV_EN
  logic                 is_div, neg_r, ge;
  logic [WIDTH:0]       shifted, diff;
`endif

  assign a_neg = is_signed_op(op) & a[WIDTH-1];
  assign b_neg = is_signed_op(op) & b[WIDTH-1];
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;
  assign sum   = mq[0] ? acc + {1'b0, opb} : acc;
  assign prod  = {acc[WIDTH-1:0], mq};
  assign last  = (cnt == '0);

`ifdef ALU_MULDIV_DIV_EN
  // With a zero divisor every trial succeeds and the remainder wraps back to |a|.
  assign shifted = {acc[WIDTH-1:0], mq[WIDTH-1]};
  assign ge      = (shifted >= {1'b0, opb});
  assign diff    = shifted - {1'b0, opb};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      mq    <= '0;
      opb   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
      neg_r  <= 1'b0;
      is_div <= 1'b0;
`endif
    end else if (load) begin
      acc   <= '0;
      mq    <= mag_a;
      opb   <= mag_b;
      cnt   <= CW'(WIDTH - 1);
      neg_q <= a_neg ^ b_neg;
`ifdef ALU_MULDIV_DIV_EN
      neg_r  <= a_neg;
      is_div <= (op == DIV) || (op == DIVU);
`endif
    end else if (step) begin
      cnt <= cnt - 1'b1;
`ifdef ALU_MULDIV_DIV_EN
      if (is_div) begin
        if (ge) begin
          acc <= {1'b0, diff[WIDTH-1:0]};
          mq  <= {mq[WIDTH-2:0], 1'b1};
        end else begin
          acc <= shifted;
          mq  <= {mq[WIDTH-2:0], 1'b0};
        end
      end else
`endif
      begin
        acc <= {1'b0, sum[WIDTH:1]};
        mq  <= {sum[0], mq[WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    prod_f = neg_q ? -prod : prod;
    hi_res = prod_f[2*WIDTH-1:WIDTH];
    lo_res = prod_f[WIDTH-1:0];
`ifdef ALU_MULDIV_DIV_EN
    if (is_div) begin
      lo_res = (opb == '0) ? '1 : (neg_q ? -mq : mq);
      hi_res = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end
`endif
  end

endmodule

// File: rtl/alu_muldiv_ctrl.sv
// ALU control decoder plus multiply/divide sequencer with HI/LO and stall request.
// Define ALU_MULDIV_DIV_EN to enable div/divu; otherwise they decode as illegal.
module alu_muldiv_ctrl import alu_pkg::*; #(parameter int WIDTH = 32) (
  input  logic               clk,
  input  logic               reset,
  alu_muldiv_ctrl_if.slave   bus
);
  state_t           state, state_n;
  mdop_t            md_op;
  logic [3:0]       alu_code;
  logic             ill, md_ok, md_fn, launch, last, done_q;
  logic [WIDTH-1:0] hi, lo, hi_res, lo_res;

  always_comb begin
    alu_code = ALU_AND;
    ill      = 1'b0;
    md_ok    = 1'b0;
    md_fn    = 1'b0;
    md_op    = MULT;
    case (bus.aluop)
      AOP_ADD: alu_code = ALU_ADD;
      AOP_SUB: alu_code = ALU_SUB;
      AOP_AND: alu_code = ALU_AND;
      default: begin
        case (bus.funct)
          F_ADD, F_ADDU:  alu_code = ALU_ADD;
          F_SUB, F_SUBU:  alu_code = ALU_SUB;
          F_AND:          alu_code = ALU_AND;
          F_OR:           alu_code = ALU_OR;
          F_XOR:          alu_code = ALU_XOR;
          F_NOR:          alu_code = ALU_NOR;
          F_SLT:          alu_code = ALU_SLT;
          F_SLTU:         alu_code = ALU_SLTU;
          F_MFHI, F_MFLO: begin alu_code = ALU_ADD; md_fn = 1'b1; end
          F_MULT:  begin alu_code = ALU_ADD; md_fn = 1'b1; md_ok = 1'b1; md_op = MULT;  end
          F_MULTU: begin alu_code = ALU_ADD; md_fn = 1'b1; md_ok = 1'b1; md_op = MULTU; end
`ifdef ALU_MULDIV_DIV_EN
          F_DIV:   begin alu_code = ALU_ADD; md_fn = 1'b1; md_ok = 1'b1; md_op = DIV;   end
          F_DIVU:  begin alu_code = ALU_ADD; md_fn = 1'b1; md_ok = 1'b1; md_op = DIVU;  end
`else
          F_DIV, F_DIVU:  begin ill = 1'b1; md_fn = 1'b1; end
`endif
          default:        ill = 1'b1;
        endcase
      end
    endcase
  end

  assign launch = (state == IDLE) && bus.start && md_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (launch) state_n = RUN;
      RUN:     if (last)   state_n = FIX;
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  muldiv_engine #(.WIDTH(WIDTH)) u_engine (
    .clk    (clk),
    .reset  (reset),
    .load   (launch),
    .step   (state == RUN),
    .op     (md_op),
    .a      (bus.a),
    .b      (bus.b),
    .last   (last),
    .hi_res (hi_res),
    .lo_res (lo_res)
  );

  // HI/LO only move in FIX, so mfhi/mflo during a run still see the previous result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == FIX);
      if (state == FIX) begin
        hi <= hi_res;
        lo <= lo_res;
      end
    end
  end

  assign bus.alucontrol = alu_code;
  assign bus.illegal    = ill;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_q;
  assign bus.stall      = (state != IDLE) && md_fn;
  assign bus.state      = state;
  assign bus.hilo_out   = (bus.aluop != AOP_FUNCT) ? '0 :
                          (bus.funct == F_MFHI)    ? hi :
                          (bus.funct == F_MFLO)    ? lo : '0;

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Self-checking bench for alu_muldiv_ctrl: per-cycle reference model plus literal pins.
// Follows ALU_MULDIV_DIV_EN the same way as the design.
module tb_alu_muldiv_ctrl;
  localparam int W = 32;
`ifdef ALU_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam logic [5:0] MFHI = 6'h10, MFLO = 6'h12, MULT = 6'h18, MULTU = 6'h19,
                         DIV = 6'h1A, DIVU = 6'h1B;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [W-1:0] exp_q[$];

  alu_muldiv_ctrl_if #(.WIDTH(W)) bus ();
  alu_muldiv_ctrl #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  // ---------------- clock / reset
  always #5 clk = ~clk;

  initial begin
    bus.funct = '0; bus.aluop = '0; bus.start = 1'b0; bus.a = '0; bus.b = '0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  end

  // ---------------- reference model
  function automatic logic [4:0] ref_dec(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 5'h02;
    if (op == 2'b01) return 5'h06;
    if (op == 2'b11) return 5'h00;
    case (f)
      6'h20, 6'h21:               return 5'h02;
      6'h22, 6'h23:               return 5'h06;
      6'h24:                      return 5'h00;
      6'h25:                      return 5'h01;
      6'h26:                      return 5'h03;
      6'h27:                      return 5'h04;
      6'h2A:                      return 5'h07;
      6'h2B:                      return 5'h0F;
      6'h10, 6'h12, 6'h18, 6'h19: return 5'h02;
      6'h1A, 6'h1B:               return DIV_EN ? 5'h02 : 5'h10;
      default:                    return 5'h10;
    endcase
  endfunction

  function automatic bit ref_launch(input logic [5:0] f);
    return (f == MULT) || (f == MULTU) || (DIV_EN && ((f == DIV) || (f == DIVU)));
  endfunction

  function automatic bit ref_md_fn(input logic [5:0] f);
    return (f == MULT) || (f == MULTU) || (f == DIV) || (f == DIVU) || (f == MFHI) || (f == MFLO);
  endfunction

  // Returns {hi, lo}.
  function automatic logic [63:0] ref_muldiv(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    if (f == MULT)  return sa * sb;
    if (f == MULTU) return ua * ub;
    if (b == 0)     return {a, 32'hFFFF_FFFF};
    if (f == DIV) begin
      sq = sa / sb;
      sr = sa % sb;
      return {sr[31:0], sq[31:0]};
    end
    uq = ua / ub;
    ur = ua % ub;
    return {ur[31:0], uq[31:0]};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare against the model
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic [63:0]  m_res = '0;
  int           m_cnt = 0;
  bit           m_done = 1'b0;
  logic [4:0]   m_dec;
  logic [W-1:0] m_hilo;

  always @(negedge clk) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_cnt = 0; m_done = 1'b0;
    end
    m_dec  = ref_dec(bus.aluop, bus.funct);
    m_hilo = (bus.aluop != 2'b10) ? '0 : (bus.funct == MFHI) ? m_hi : (bus.funct == MFLO) ? m_lo : '0;
    chk("alucontrol", W'(bus.alucontrol), W'(m_dec[3:0]));
    chk("illegal",    W'(bus.illegal),    W'(m_dec[4]));
    chk("hilo_out",   bus.hilo_out,       m_hilo);
    chk("busy",       W'(bus.busy),       W'(m_cnt != 0));
    chk("done",       W'(bus.done),       W'(m_done));
    chk("stall",      W'(bus.stall),      W'((m_cnt != 0) && bus.aluop == 2'b10 && ref_md_fn(bus.funct)));
    if (!reset) begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_hi = m_res[63:32]; m_lo = m_res[31:0]; m_done = 1'b1;
        end
      end else if (bus.start && bus.aluop == 2'b10 && ref_launch(bus.funct)) begin
        m_res = ref_muldiv(bus.funct, bus.a, bus.b);
        m_cnt = W + 1;
      end
    end
  end

  // ---------------- driver tasks
  task automatic set_in(input logic [1:0] op, input logic [5:0] f, input logic st,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk);
    #1;
    bus.aluop = op; bus.funct = f; bus.start = st; bus.a = a; bus.b = b;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic read_back();
    set_in(2'b10, MFHI, 1'b0, '0, '0);
    @(negedge clk);
    chk("hi_readback", bus.hilo_out, exp_q.pop_front());
    set_in(2'b10, MFLO, 1'b0, '0, '0);
    @(negedge clk);
    chk("lo_readback", bus.hilo_out, exp_q.pop_front());
  endtask

  task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el);
    int lat;
    exp_q.push_back(eh);
    exp_q.push_back(el);
    set_in(2'b10, f, 1'b1, a, b);
    set_in(2'b10, f, 1'b0, $urandom, $urandom);
    wait_done(lat);
    chk("done_latency", W'(lat), W'(34));
    read_back();
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus
  initial begin
    int lat;
    logic [5:0] f;
    logic [5:0] md_list[4];
    md_list[0] = MULT; md_list[1] = MULTU; md_list[2] = DIV; md_list[3] = DIVU;

    @(negedge clk);
    chk("reset_busy",  W'(bus.busy),     '0);
    chk("reset_done",  W'(bus.done),     '0);
    chk("reset_stall", W'(bus.stall),    '0);
    wait (reset == 1'b0);

    // Decode sweep: every funct under every aluop.
    for (int op = 0; op < 4; op++)
      for (int fn = 0; fn < 64; fn++)
        set_in(2'(op), 6'(fn), 1'b0, '0, '0);

    set_in(2'b10, 6'h26, 1'b0, '0, '0);
    @(negedge clk);
    chk("pin_xor", W'(bus.alucontrol), W'(4'b0011));
    set_in(2'b10, 6'h2B, 1'b0, '0, '0);
    @(negedge clk);
    chk("pin_sltu", W'(bus.alucontrol), W'(4'b1111));
    set_in(2'b10, 6'h01, 1'b0, '0, '0);
    @(negedge clk);
    chk("pin_undef_illegal", W'(bus.illegal), W'(1));
    chk("pin_undef_code",    W'(bus.alucontrol), '0);
    set_in(2'b01, 6'h26, 1'b0, '0, '0);
    @(negedge clk);
    chk("pin_aluop01", W'(bus.alucontrol), W'(4'b0110));

    run_op(MULT,  32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op(MULTU, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB);

    // Second start mid-run is ignored; mfhi while busy stalls and shows the old HI.
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd25);
    set_in(2'b10, MULT, 1'b1, 32'd5, 32'd5);
    repeat (9) set_in(2'b10, MULT, 1'b0, $urandom, $urandom);
    set_in(2'b10, MULT, 1'b1, 32'd7, 32'd7);
    set_in(2'b10, MFHI, 1'b0, '0, '0);
    @(negedge clk);
    chk("pin_stall_busy", W'(bus.stall), W'(1));
    chk("pin_old_hi",     bus.hilo_out,  32'd6);
    wait_done(lat);
    chk("done_seen", W'(lat != 0), W'(1));
    read_back();

    if (DIV_EN) begin
      run_op(DIVU, 32'd100,        32'd7,        32'd2,        32'd14);
      run_op(DIV,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op(DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,       32'h8000_0000);
      run_op(DIV,  32'd5,          32'd0,        32'd5,        32'hFFFF_FFFF);
    end else begin
      set_in(2'b10, DIV, 1'b1, 32'd5, 32'd1);
      @(negedge clk);
      chk("pin_div_illegal", W'(bus.illegal), W'(1));
      chk("pin_div_code",    W'(bus.alucontrol), '0);
      set_in(2'b10, DIVU, 1'b1, 32'd5, 32'd1);
      set_in(2'b10, DIVU, 1'b0, 32'd5, 32'd1);
      repeat (3) begin
        @(negedge clk);
        chk("pin_div_no_busy", W'(bus.busy), '0);
      end
    end

    // Reset mid-operation.
    f = DIV_EN ? DIV : MULT;
    set_in(2'b10, f, 1'b1, 32'd123, 32'd456);
    repeat (14) set_in(2'b10, f, 1'b0, $urandom, $urandom);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.funct = MFHI;
    @(negedge clk);
    chk("pin_rst_busy", W'(bus.busy), '0);
    chk("pin_rst_hi",   bus.hilo_out, '0);
    @(posedge clk);
    #1 bus.funct = MFLO;
    @(negedge clk);
    chk("pin_rst_lo",   bus.hilo_out, '0);
    chk("pin_rst_done", W'(bus.done), '0);
    @(posedge clk);
    #1 reset = 1'b0;
    run_op(MULT, 32'd9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFEE);

    // Randomised traffic, checked every cycle by the model.
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: f = md_list[$urandom_range(0, 3)];
        4:          f = MFHI;
        5:          f = MFLO;
        default:    f = 6'($urandom_range(0, 63));
      endcase
      set_in(($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b10, f,
             ($urandom_range(0, 2) == 0), pick_operand(), pick_operand());
    end
    repeat (40) set_in(2'b10, MFLO, 1'b0, '0, '0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
